cpu_oci_dct_sequencer: RTL

//  Debug compressed-trace (DCT) sequencer for one Nios II OCI block.
//  - Arbitrates 2-bit trace atoms from two requesters: instruction trace (src0) and data trace (src1).
//  - Packs accepted atoms LSB-first into a 30-bit dct_buffer plus a 4-bit dct_count.
//  - Hands each packed word to the trace sink / test bench over a valid/ready interface.
//  - Sits between the OCI trace sources and the trace capture path / oci_test_bench.

---
 rtl/cpu_oci_dct_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_oci_dct_sequencer.sv
// ============================================================================
// Module      : cpu_oci_dct_sequencer
// Description : Debug compressed-trace (DCT) sequencer for one Nios II OCI
//               block. It arbitrates 2-bit trace atoms from the instruction
//               trace source (src0) and the data trace source (src1). Accepted
//               atoms are packed LSB-first into a word. Each packed word is
//               handed to the trace sink over a valid/ready interface.
// Ports       : clk, reset            - clock, asynchronous active-high reset
//               src0_valid/atom/ready - instruction-trace atom handshake
//               src1_valid/atom/ready - data-trace atom handshake
//               flush / flush_done    - request partial-word emission / done pulse
//               dct_buffer/count      - packed word and number of valid atoms
//               dct_valid / dct_ready - output word handshake
//               dct_timestamp         - cycle stamp of the word's first atom
// Options     : DCT_TIMESTAMP_EN      - enables the free-running timestamp;
//                                       when undefined, dct_timestamp is 0
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_oci_dct_sequencer #(
    parameter int NUM_ATOMS = 15,
    parameter int ATOM_W    = 2,
    parameter int TS_W      = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               src0_valid,
    input  logic [ATOM_W-1:0]                  src0_atom,
    output logic                               src0_ready,
    input  logic                               src1_valid,
    input  logic [ATOM_W-1:0]                  src1_atom,
    output logic                               src1_ready,
    input  logic                               flush,
    output logic                               flush_done,
    output logic [NUM_ATOMS*ATOM_W-1:0]        dct_buffer,
    output logic [$clog2(NUM_ATOMS+1)-1:0]     dct_count,
    output logic                               dct_valid,
    input  logic                               dct_ready,
    output logic [TS_W-1:0]                    dct_timestamp
);

    localparam int               BUF_W  = NUM_ATOMS * ATOM_W;
    localparam int               CNT_W  = $clog2(NUM_ATOMS + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(NUM_ATOMS);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [BUF_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pref1;       // 1: src1 wins the next tie
    logic             r_flush_pend;  // flush seen while a word was held
    logic             r_word_flush;  // held word was emitted by a flush
    logic             r_empty_done;  // flush found nothing to emit
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    logic             w_fill;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_any;
    logic [ATOM_W-1:0] w_atom;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_shift;
    logic [BUF_W-1:0] w_slot;
    logic [BUF_W-1:0] w_acc_next;
    logic             w_flush_req;
    logic             w_emit;
    logic             w_empty_flush;
    logic             w_handoff;

    // The count never reaches NUM_ATOMS in FILL (a full word leaves at once).
    // The room term keeps the count saturating regardless.
    assign w_fill   = (r_state == S_FILL) && (r_cnt != C_FULL);
    assign w_grant0 = w_fill & src0_valid & (~src1_valid | ~r_pref1);
    assign w_grant1 = w_fill & src1_valid & (~src0_valid |  r_pref1);
    assign w_any    = w_grant0 | w_grant1;
    assign w_atom   = w_grant0 ? src0_atom : src1_atom;

    assign w_cnt_next = r_cnt + CNT_W'(w_any);
    assign w_shift    = 32'(r_cnt) * ATOM_W;
    assign w_slot     = {{(BUF_W-ATOM_W){1'b0}}, w_atom} << w_shift;
    assign w_acc_next = w_any ? (r_acc | w_slot) : r_acc;

    assign w_flush_req   = flush | r_flush_pend;
    assign w_emit        = w_fill & ((w_cnt_next == C_FULL) |
                                     (w_flush_req & (w_cnt_next != '0)));
    assign w_empty_flush = w_fill & w_flush_req & (w_cnt_next == '0);
    assign w_handoff     = r_valid & dct_ready;

    assign src0_ready = w_grant0;
    assign src1_ready = w_grant1;
    assign dct_buffer = r_buf;
    assign dct_count  = r_count;
    assign dct_valid  = r_valid;
    assign flush_done = r_empty_done | (w_handoff & r_word_flush);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:  if (w_emit)    w_state_next = S_HOLD;
            S_HOLD:  if (w_handoff) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    // Accumulator, arbitration pointer, output word and flush bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_pref1      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_word_flush <= 1'b0;
            r_empty_done <= 1'b0;
            r_buf        <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_empty_done <= w_empty_flush;
            if (w_any) begin
                r_pref1 <= w_grant0;
            end
            if (r_state == S_FILL) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                // A flush in FILL is always consumed in the same cycle:
                // either it emits a word or it completes as an empty flush.
                r_flush_pend <= 1'b0;
                if (w_emit) begin
                    r_buf        <= w_acc_next;
                    r_count      <= w_cnt_next;
                    r_valid      <= 1'b1;
                    r_word_flush <= w_flush_req;
                end
            end else begin
                // A flush during HOLD applies to the next word, not this one.
                if (flush) begin
                    r_flush_pend <= 1'b1;
                end
                if (w_handoff) begin
                    r_valid      <= 1'b0;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                    r_word_flush <= 1'b0;
                end
            end
        end
    end

`ifdef DCT_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_ctr;
    logic [TS_W-1:0] r_ts_first;
    logic [TS_W-1:0] r_ts_out;

    // Stamp is taken when slot 0 is filled. When slot 0 is filled in the
    // emitting cycle (one-atom flush), the live counter is used directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts_ctr   <= '0;
            r_ts_first <= '0;
            r_ts_out   <= '0;
        end else begin
            r_ts_ctr <= r_ts_ctr + 1'b1;
            if (w_any && (r_cnt == '0)) begin
                r_ts_first <= r_ts_ctr;
            end
            if (w_emit) begin
                r_ts_out <= (r_cnt == '0) ? r_ts_ctr : r_ts_first;
            end
        end
    end

    assign dct_timestamp = r_ts_out;
`else
    assign dct_timestamp = '0;
`endif

endmodule

`default_nettype wire
